// File: rtl/mem_map_pkg.sv
// Memory-map, write-back select and timer control constants shared by the
// MEM/WB stage, its timer peripheral and anything that decodes the same map.
package mem_map_pkg;

  // Peripheral register offsets from the peripheral window base (word aligned).
  localparam logic [7:0] OFF_TH      = 8'h00;
  localparam logic [7:0] OFF_TL      = 8'h04;
  localparam logic [7:0] OFF_TCON    = 8'h08;
  localparam logic [7:0] OFF_LED     = 8'h0C;
  localparam logic [7:0] OFF_SYSTICK = 8'h14;

  // MemToReg write-back select encoding; 2'b11 behaves like MTR_ALU.
  localparam logic [1:0] MTR_ALU  = 2'b00;
  localparam logic [1:0] MTR_MEM  = 2'b01;
  localparam logic [1:0] MTR_LINK = 2'b10;

  // TCON bit positions.
  localparam int TCON_EN     = 0;
  localparam int TCON_IRQ_EN = 1;
  localparam int TCON_IRQ    = 2;

  // True when a word offset inside the peripheral window names a register.
  function automatic logic periph_mapped(input logic [7:0] off);
    return (off == OFF_TH) || (off == OFF_TL) || (off == OFF_TCON) ||
           (off == OFF_LED) || (off == OFF_SYSTICK);
  endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// EX/MEM pipeline register outputs as seen by the memory stage.
// There is no valid/ready handshake on this bus: the pipeline advances every
// cycle, and an empty slot (bubble) is simply RegWr=0, MemRd=0, MemWr=0.
interface mem_wb_stage_if;
  import mem_map_pkg::*;

  logic        MemRd_EX_MEM;
  logic        MemWr_EX_MEM;
  logic        RegWr_EX_MEM;
  logic [1:0]  MemToReg_EX_MEM;
  logic [4:0]  AddrC_EX_MEM;
  logic [31:0] ALUOut_EX_MEM;
  logic [31:0] DatabusB_EX_MEM;
  logic [31:0] PCNew_EX_MEM;

  // EX/MEM register side.
  modport master (
    output MemRd_EX_MEM, MemWr_EX_MEM, RegWr_EX_MEM, MemToReg_EX_MEM,
    output AddrC_EX_MEM, ALUOut_EX_MEM, DatabusB_EX_MEM, PCNew_EX_MEM
  );

  // Memory stage side.
  modport slave (
    input MemRd_EX_MEM, MemWr_EX_MEM, RegWr_EX_MEM, MemToReg_EX_MEM,
    input AddrC_EX_MEM, ALUOut_EX_MEM, DatabusB_EX_MEM, PCNew_EX_MEM
  );
endinterface

// File: rtl/timer_periph.sv
// Reload timer (TH/TL/TCON) with sticky interrupt flag, plus the free-running
// systick counter. Reads are combinational on the supplied offset.
module timer_periph
  import mem_map_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [7:0]  offset,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq,
  output logic [31:0] systick
);

  logic [31:0] th;
  logic [31:0] tl;
  logic [2:0]  tcon;

  logic wr_th;
  logic wr_tl;
  logic wr_tcon;

  assign wr_th   = wr_en && (offset == OFF_TH);
  assign wr_tl   = wr_en && (offset == OFF_TL);
  assign wr_tcon = wr_en && (offset == OFF_TCON);

  // Free-running cycle counter; wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (reset) systick <= '0;
    else       systick <= systick + 32'd1;
  end

  // Timer state: a software write to TL or TCON wins over the count/reload,
  // and is then the only TL/TCON change that cycle. Reload uses the old TH.
  always_ff @(posedge clk) begin
    if (reset) begin
      th   <= '0;
      tl   <= '0;
      tcon <= '0;
    end else begin
      if (wr_th) th <= wdata;
      if (wr_tl) begin
        tl <= wdata;
      end else if (wr_tcon) begin
        tcon <= wdata[2:0];
      end else if (tcon[TCON_EN]) begin
        if (tl == 32'hFFFF_FFFF) begin
          tl <= th;
          if (tcon[TCON_IRQ_EN]) tcon[TCON_IRQ] <= 1'b1;
        end else begin
          tl <= tl + 32'd1;
        end
      end
    end
  end

  // Register read mux; offsets not owned by the timer read as zero.
  always_comb begin
    rdata = '0;
    case (offset)
      OFF_TH:      rdata = th;
      OFF_TL:      rdata = tl;
      OFF_TCON:    rdata = {29'd0, tcon};
      OFF_SYSTICK: rdata = systick;
      default:     rdata = '0;
    endcase
  end

  assign irq = tcon[TCON_IRQ];

endmodule

// File: rtl/mem_wb_stage.sv
// Memory stage and MEM/WB pipeline register: word data RAM, LED register and
// the timer peripheral behind a small memory map, followed by the write-back
// select and the register that drives the register-file write port.
module mem_wb_stage
  import mem_map_pkg::*;
#(
  parameter int          RAM_WORDS   = 256,
  parameter logic [31:0] PERIPH_BASE = 32'h4000_0000
) (
  input  logic             clk,
  input  logic             reset,
  mem_wb_stage_if.slave    ex_mem,
  output logic [31:0]      MemReadData,
  output logic             RegWr_MEM_WB,
  output logic [4:0]       AddrC_MEM_WB,
  output logic [31:0]      WriteData_MEM_WB,
  output logic [7:0]       led,
  output logic             irq_timer,
  output logic [31:0]      systick
);

  localparam int          IDX_W     = $clog2(RAM_WORDS);
  localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) << 2;

  logic [31:0] ram [RAM_WORDS];

  logic [IDX_W-1:0] ram_idx;
  logic             ram_hit;
  logic [31:0]      periph_word;
  logic [7:0]       periph_off;
  logic             periph_sel;
  logic             periph_wr;
  logic [31:0]      timer_rdata;
  logic [31:0]      sel_rdata;
  logic [31:0]      wb_data;

  // Address decode; the byte-offset bits [1:0] never matter.
  assign ram_hit     = {1'b0, ex_mem.ALUOut_EX_MEM} < RAM_BYTES;
  assign ram_idx     = ex_mem.ALUOut_EX_MEM[IDX_W+1:2];
  assign periph_word = (ex_mem.ALUOut_EX_MEM & 32'hFFFF_FFFC) - PERIPH_BASE;
  assign periph_off  = periph_word[7:0];
  assign periph_sel  = !ram_hit && (periph_word[31:8] == 24'd0) &&
                       periph_mapped(periph_off);
  assign periph_wr   = ex_mem.MemWr_EX_MEM && periph_sel;

  timer_periph u_timer (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (periph_wr),
    .offset  (periph_off),
    .wdata   (ex_mem.DatabusB_EX_MEM),
    .rdata   (timer_rdata),
    .irq     (irq_timer),
    .systick (systick)
  );

  // Data RAM store port; contents survive reset.
  always_ff @(posedge clk) begin
    if (ex_mem.MemWr_EX_MEM && ram_hit) ram[ram_idx] <= ex_mem.DatabusB_EX_MEM;
  end

  // LED register, low byte of the store data.
  always_ff @(posedge clk) begin
    if (reset)                                  led <= '0;
    else if (periph_wr && periph_off == OFF_LED) led <= ex_mem.DatabusB_EX_MEM[7:0];
  end

  // Combinational load path; returns pre-write data when a store hits too.
  always_comb begin
    sel_rdata = '0;
    if (ram_hit)                   sel_rdata = ram[ram_idx];
    else if (periph_sel) begin
      if (periph_off == OFF_LED)   sel_rdata = {24'd0, led};
      else                         sel_rdata = timer_rdata;
    end
    MemReadData = ex_mem.MemRd_EX_MEM ? sel_rdata : 32'd0;
  end

  // Write-back select; the reserved code falls back to the ALU result.
  always_comb begin
    wb_data = ex_mem.ALUOut_EX_MEM;
    case (ex_mem.MemToReg_EX_MEM)
      MTR_MEM:  wb_data = MemReadData;
      MTR_LINK: wb_data = ex_mem.PCNew_EX_MEM;
      default:  wb_data = ex_mem.ALUOut_EX_MEM;
    endcase
  end

  // MEM/WB pipeline register, captured every cycle (no stall, no flush).
  always_ff @(posedge clk) begin
    if (reset) begin
      RegWr_MEM_WB     <= 1'b0;
      AddrC_MEM_WB     <= '0;
      WriteData_MEM_WB <= '0;
    end else begin
      RegWr_MEM_WB     <= ex_mem.RegWr_EX_MEM;
      AddrC_MEM_WB     <= ex_mem.AddrC_EX_MEM;
      WriteData_MEM_WB <= wb_data;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed checks with literal expectations, then
// randomized traffic compared every cycle against a behavioural memory-map model.
module tb_mem_wb_stage;
  import mem_map_pkg::*;

  localparam int          RAM_WORDS = 256;
  localparam logic [31:0] PBASE     = 32'h4000_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_wb_stage_if bus ();

  logic [31:0] MemReadData;
  logic        RegWr_MEM_WB;
  logic [4:0]  AddrC_MEM_WB;
  logic [31:0] WriteData_MEM_WB;
  logic [7:0]  led;
  logic        irq_timer;
  logic [31:0] systick;

  mem_wb_stage #(.RAM_WORDS(RAM_WORDS), .PERIPH_BASE(PBASE)) dut (
    .clk              (clk),
    .reset            (reset),
    .ex_mem           (bus.slave),
    .MemReadData      (MemReadData),
    .RegWr_MEM_WB     (RegWr_MEM_WB),
    .AddrC_MEM_WB     (AddrC_MEM_WB),
    .WriteData_MEM_WB (WriteData_MEM_WB),
    .led              (led),
    .irq_timer        (irq_timer),
    .systick          (systick)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mdl_ram [int];
  int          written_q[$];
  logic [31:0] mdl_th, mdl_tl, mdl_systick;
  logic [2:0]  mdl_tcon;
  logic [7:0]  mdl_led;
  logic        mdl_regwr;
  logic [4:0]  mdl_addrc;
  logic [31:0] exp_q[$];

  function automatic logic [31:0] mdl_read();
    logic [31:0] a;
    a = bus.ALUOut_EX_MEM;
    if (!bus.MemRd_EX_MEM) return 32'd0;
    if (a < 32'(RAM_WORDS * 4))
      return mdl_ram.exists(int'(a >> 2)) ? mdl_ram[int'(a >> 2)] : 32'd0;
    case ((a & 32'hFFFF_FFFC) - PBASE)
      32'h00:  return mdl_th;
      32'h04:  return mdl_tl;
      32'h08:  return {29'd0, mdl_tcon};
      32'h0C:  return {24'd0, mdl_led};
      32'h14:  return mdl_systick;
      default: return 32'd0;
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs held during that cycle.
  task automatic model_step();
    logic [31:0] a, off, db, rd, wb;
    bit is_ram, w_tl, w_tcon;
    if (reset) begin
      mdl_th = 0; mdl_tl = 0; mdl_tcon = 0; mdl_systick = 0; mdl_led = 0;
      mdl_regwr = 0; mdl_addrc = 0;
      exp_q.push_back(32'd0);
      return;
    end
    a      = bus.ALUOut_EX_MEM;
    db     = bus.DatabusB_EX_MEM;
    off    = (a & 32'hFFFF_FFFC) - PBASE;
    is_ram = a < 32'(RAM_WORDS * 4);
    rd     = mdl_read();
    case (bus.MemToReg_EX_MEM)
      2'b01:   wb = rd;
      2'b10:   wb = bus.PCNew_EX_MEM;
      default: wb = a;
    endcase
    w_tl   = bus.MemWr_EX_MEM && !is_ram && off == 32'h04;
    w_tcon = bus.MemWr_EX_MEM && !is_ram && off == 32'h08;
    if (w_tl) mdl_tl = db;
    else if (w_tcon) mdl_tcon = db[2:0];
    else if (mdl_tcon[0]) begin
      if (mdl_tl == 32'hFFFF_FFFF) begin
        mdl_tl = mdl_th;
        if (mdl_tcon[1]) mdl_tcon[2] = 1'b1;
      end else mdl_tl = mdl_tl + 1;
    end
    if (bus.MemWr_EX_MEM) begin
      if (is_ram) begin
        if (!mdl_ram.exists(int'(a >> 2))) written_q.push_back(int'(a >> 2));
        mdl_ram[int'(a >> 2)] = db;
      end else if (off == 32'h00) mdl_th = db;
      else if (off == 32'h0C) mdl_led = db[7:0];
    end
    mdl_systick = mdl_systick + 1;
    mdl_regwr   = bus.RegWr_EX_MEM;
    mdl_addrc   = bus.AddrC_EX_MEM;
    exp_q.push_back(wb);
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      check("regwr", {31'd0, RegWr_MEM_WB}, {31'd0, mdl_regwr});
      check("addrc", {27'd0, AddrC_MEM_WB}, {27'd0, mdl_addrc});
      if (exp_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL wdata: expected queue empty at %0t", $time);
      end else check("wdata", WriteData_MEM_WB, exp_q.pop_front());
      check("memread", MemReadData, mdl_read());
      check("led", {24'd0, led}, {24'd0, mdl_led});
      check("irq", {31'd0, irq_timer}, {31'd0, mdl_tcon[2]});
      check("systick", systick, mdl_systick);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic rd, input logic wr, input logic rw, input logic [1:0] mtr,
                        input logic [4:0] ac, input logic [31:0] alu, input logic [31:0] db,
                        input logic [31:0] pc);
    bus.MemRd_EX_MEM    = rd;
    bus.MemWr_EX_MEM    = wr;
    bus.RegWr_EX_MEM    = rw;
    bus.MemToReg_EX_MEM = mtr;
    bus.AddrC_EX_MEM    = ac;
    bus.ALUOut_EX_MEM   = alu;
    bus.DatabusB_EX_MEM = db;
    bus.PCNew_EX_MEM    = pc;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic sw(input logic [31:0] addr, input logic [31:0] data);
    set_in(1'b0, 1'b1, 1'b0, MTR_ALU, 5'd0, addr, data, 32'd0);
    tick();
  endtask

  task automatic lw_set(input logic [31:0] addr, input logic [4:0] ac);
    set_in(1'b1, 1'b0, 1'b1, MTR_MEM, ac, addr, 32'd0, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    logic [31:0] s0, addr, data;
    logic [7:0]  offs [7];
    offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18};

    // Reset held two cycles with RegWr=1 on the bus.
    reset  = 1'b1;
    cmp_en = 1'b1;
    set_in(1'b0, 1'b0, 1'b1, MTR_ALU, 5'd7, 32'h55, 32'd0, 32'd0);
    tick();
    check("rst_regwr", {31'd0, RegWr_MEM_WB}, 32'd0);
    check("rst_wdata", WriteData_MEM_WB, 32'd0);
    check("rst_addrc", {27'd0, AddrC_MEM_WB}, 32'd0);
    tick();
    check("rst_systick", systick, 32'd0);
    check("rst_led_irq", {23'd0, led, irq_timer}, 32'd0);
    reset = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, MTR_ALU, 5'd0, 32'd0, 32'd0, 32'd0);
    tick();
    check("systick_1", systick, 32'd1);
    tick();
    check("systick_2", systick, 32'd2);

    // Store then load, including unaligned low address bits.
    sw(32'h10, 32'hDEAD_BEEF);
    lw_set(32'h10, 5'd8);
    check("lw_comb", MemReadData, 32'hDEAD_BEEF);
    tick();
    check("lw_wdata", WriteData_MEM_WB, 32'hDEAD_BEEF);
    check("lw_addrc", {27'd0, AddrC_MEM_WB}, 32'd8);
    check("lw_regwr", {31'd0, RegWr_MEM_WB}, 32'd1);
    lw_set(32'h13, 5'd9);
    tick();
    check("lw_13", WriteData_MEM_WB, 32'hDEAD_BEEF);

    // Link, ALU and reserved select paths.
    set_in(1'b0, 1'b0, 1'b1, MTR_LINK, 5'd31, 32'h1234, 32'd0, 32'h0040_0024);
    tick();
    check("link", WriteData_MEM_WB, 32'h0040_0024);
    set_in(1'b0, 1'b0, 1'b1, MTR_ALU, 5'd3, 32'h55, 32'd0, 32'h9999);
    tick();
    check("alu", WriteData_MEM_WB, 32'h55);
    set_in(1'b0, 1'b0, 1'b1, 2'b11, 5'd4, 32'h77, 32'd0, 32'h9999);
    tick();
    check("mtr11", WriteData_MEM_WB, 32'h77);

    // Timer overflow with reload and sticky irq.
    sw(PBASE + 32'h00, 32'hFFFF_FFFD);
    sw(PBASE + 32'h04, 32'hFFFF_FFFE);
    sw(PBASE + 32'h08, 32'd3);
    lw_set(PBASE + 32'h04, 5'd1);
    check("tl_start", MemReadData, 32'hFFFF_FFFE);
    tick();
    check("tl_max", MemReadData, 32'hFFFF_FFFF);
    check("irq_pre", {31'd0, irq_timer}, 32'd0);
    tick();
    check("tl_reload", MemReadData, 32'hFFFF_FFFD);
    check("irq_set", {31'd0, irq_timer}, 32'd1);
    tick();
    tick();
    check("tl_max2", MemReadData, 32'hFFFF_FFFF);
    // Collision: TL store beats the reload; irq untouched.
    sw(PBASE + 32'h04, 32'h100);
    lw_set(PBASE + 32'h04, 5'd1);
    check("tl_collide", MemReadData, 32'h100);
    check("irq_sticky", {31'd0, irq_timer}, 32'd1);
    tick();
    sw(PBASE + 32'h08, 32'd3);
    check("irq_clear", {31'd0, irq_timer}, 32'd0);
    lw_set(PBASE + 32'h04, 5'd1);
    check("tl_hold_on_tcon_wr", MemReadData, 32'h101);
    tick();

    // Unmapped load, read-only systick, LED width.
    lw_set(PBASE + 32'h100, 5'd2);
    tick();
    check("unmapped", WriteData_MEM_WB, 32'd0);
    s0 = systick;
    sw(PBASE + 32'h14, 32'h0);
    check("systick_ro", systick, s0 + 32'd1);
    sw(PBASE + 32'h0C, 32'h1A5);
    check("led", {24'd0, led}, 32'hA5);

    // Randomized traffic checked by the compare process.
    for (int i = 0; i < 800; i++) begin
      case ($urandom_range(0, 9))
        0, 1: begin
          addr = {22'd0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3)), 2'b00} >> 2;
          addr = (addr << 2) | 32'($urandom_range(0, 3));
          data = $urandom;
          set_in(mdl_ram.exists(int'(addr >> 2)) ? 1'($urandom_range(0, 1)) : 1'b0, 1'b1,
                 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 5'($urandom_range(0, 31)), addr, data, $urandom);
        end
        2, 3: begin
          if (written_q.size() == 0) addr = PBASE + 32'h14;
          else addr = (32'(written_q[$urandom_range(0, written_q.size() - 1)]) << 2)
                      | 32'($urandom_range(0, 3));
          set_in(1'b1, 1'b0, 1'($urandom_range(0, 1)), MTR_MEM, 5'($urandom_range(0, 31)),
                 addr, $urandom, $urandom);
        end
        4: set_in(1'b1, 1'b0, 1'b1, MTR_MEM, 5'($urandom_range(0, 31)),
                  PBASE + 32'(offs[$urandom_range(0, 6)]) + 32'($urandom_range(0, 3)),
                  $urandom, $urandom);
        5: begin
          addr = PBASE + 32'(offs[$urandom_range(0, 6)]);
          data = $urandom;
          if (addr == PBASE + 32'h04 && $urandom_range(0, 1) == 1)
            data = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
          if (addr == PBASE + 32'h08) data = 32'($urandom_range(0, 7));
          set_in(1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), addr, data, $urandom);
        end
        6: set_in(1'b1, 1'($urandom_range(0, 1)), 1'b1, MTR_MEM, 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 1) == 1) ? 32'h400 + 32'($urandom_range(0, 255))
                                             : 32'h8000_0000 | $urandom,
                  $urandom, $urandom);
        7: set_in(1'b0, 1'b0, 1'($urandom_range(0, 1)), MTR_LINK, 5'($urandom_range(0, 31)),
                  $urandom, $urandom, $urandom);
        8: set_in(1'b0, 1'b0, 1'($urandom_range(0, 1)), MTR_ALU, 5'($urandom_range(0, 31)),
                  $urandom, $urandom, $urandom);
        default: set_in(1'b0, 1'b0, 1'b1, 2'b11, 5'($urandom_range(0, 31)),
                        $urandom, $urandom, $urandom);
      endcase
      tick();
    end

    set_in(1'b0, 1'b0, 1'b0, MTR_ALU, 5'd0, 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
Consumer end of the EX/MEM pipeline interface. Takes the EX/MEM register outputs and performs the memory access: word data RAM plus memory-mapped timer, LED and systick registers. Selects the write-back value and registers it into the MEM/WB pipeline register that drives the register-file write port. Also raises the timer interrupt request toward the ID-stage PC-select logic.

Parameters:
RAM_WORDS, 256, data RAM depth in 32-bit words (power of two)
PERIPH_BASE, 32'h40000000, base address of the peripheral window

Ports:
clk  in  1  system clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
MemRd_EX_MEM  in  1  load enable
MemWr_EX_MEM  in  1  store enable
RegWr_EX_MEM  in  1  register-file write enable from EX/MEM
MemToReg_EX_MEM  in  2  write-back select: 00 ALU, 01 memory, 10 PCNew (link)
AddrC_EX_MEM  in  5  destination register
ALUOut_EX_MEM  in  32  effective address / ALU result
DatabusB_EX_MEM  in  32  store data
PCNew_EX_MEM  in  32  link value (PC+4)
MemReadData  out  32  combinational load data (for MEM-stage forwarding)
RegWr_MEM_WB  out  1  registered write enable
AddrC_MEM_WB  out  5  registered destination register
WriteData_MEM_WB  out  32  registered write-back data
led  out  8  LED register
irq_timer  out  1  timer interrupt request (= TCON[2])
systick  out  32  free-running cycle counter

Behaviour:
- Reset (reset=1 at a rising edge): RegWr_MEM_WB=0, AddrC_MEM_WB=0, WriteData_MEM_WB=0, led=0, TH=0, TL=0, TCON=0, systick=0, irq_timer=0. RAM contents are not cleared.
- Decode: address bits [1:0] are ignored.
  - RAM hit: ALUOut < RAM_WORDS*4. RAM index = ALUOut[log2(RAM_WORDS)+1:2].
  - Peripheral offsets from PERIPH_BASE: 0x00 TH, 0x04 TL, 0x08 TCON[2:0], 0x0C LED[7:0], 0x14 systick (read-only).
  - Any other address is unmapped.
- Reads: combinational.
  - MemReadData = selected register, zero-extended to 32 bits.
  - Unmapped address or MemRd=0 returns 0.
- Writes: happen at the rising edge when MemWr=1.
  - RAM write is synchronous. A read of the same address in the same cycle returns the old data.
  - Writes to unmapped addresses or to systick are ignored.
- MemRd=1 and MemWr=1 together: the write occurs; the read returns pre-write data.
- Write-back mux: 00 ALUOut_EX_MEM, 01 MemReadData, 10 PCNew_EX_MEM, 11 ALUOut_EX_MEM.
- MEM/WB register: one-cycle latency. RegWr, AddrC and the mux output are captured every edge. No stall and no flush input; bubbles arrive as RegWr=0.
- AddrC=0 passes through unchanged. Register-file writes to $0 are suppressed in the register file, not here.
- systick increments every cycle and wraps 0xFFFFFFFF -> 0.
- Timer, while TCON[0] (enable) is set:
  - If TL==0xFFFFFFFF, then TL<=TH; if TCON[1] (irq enable) is also set, TCON[2]<=1.
  - Otherwise TL<=TL+1.
- Timer, while TCON[0]=0: TL holds its value.
- A software write to TL or TCON in the same cycle as a timer update takes priority over the update; that write is the only TL/TCON change that cycle.
- TCON[2] is sticky and is cleared only by a software TCON write with bit2=0.

Decomposition:
- Package mem_map_pkg:
  - address offset constants for TH, TL, TCON, LED, SYSTICK
  - MemToReg encoding constants (MTR_ALU, MTR_MEM, MTR_LINK)
  - TCON bit index constants
- Sub-module timer_periph:
  - contents: TH, TL, TCON, systick and the irq logic
  - inputs: clk, reset, write strobe, offset, write data
  - outputs: read data, irq
- Data RAM and the MEM/WB register are implemented in the top level.

Test Plan:
- Reset: assert reset for 2 cycles while driving RegWr=1 -> all outputs 0. After release, systick reads 1 after the first edge and 2 after the second.
- Store then load: SW 0xDEADBEEF to 0x10, then LW from 0x10 with MemToReg=01, AddrC=8 -> one cycle later WriteData_MEM_WB=0xDEADBEEF, AddrC_MEM_WB=8, RegWr_MEM_WB=1. A load from 0x13 returns the same value.
- Link and ALU paths: MemToReg=10 with PCNew=0x00400024 -> WriteData=0x00400024. MemToReg=00 with ALUOut=0x55 -> WriteData=0x55.
- Timer overflow: write TH=0xFFFFFFFD, TL=0xFFFFFFFE, TCON=3 -> TL=0xFFFFFFFF next cycle; the cycle after that TL=0xFFFFFFFD and irq_timer=1; irq stays 1 until a TCON write of 0x3 clears it.
- Write/count collision: timer enabled, TL=0xFFFFFFFF, store TL=0x100 in that cycle -> TL=0x100, no reload, irq unchanged.
- Unmapped and read-only addresses: LW from 0x40000100 -> WriteData=0. SW to systick -> counting is unaffected. SW 0x1A5 to LED -> led=0xA5.
